// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined logic unit: opcode width, opcode
// enumeration and the bitwise result function used by the S2 stage.
package logic_unit_pkg;

  localparam int OP_W  = 3;
  localparam int MAX_W = 64;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NOT  = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  // Computed at full width; callers truncate to their own WIDTH.
  function automatic logic [MAX_W-1:0] lu_eval(op_e op, logic [MAX_W-1:0] a,
                                                logic [MAX_W-1:0] b);
    logic [MAX_W-1:0] r;
    r = a;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = ~a;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      OP_PASS: r = a;
      default: r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_unit_if.sv
// Operand/result handshake bundle for logic_unit_pipe.
// The pop_cnt signal exists only when LOGIC_UNIT_POPCOUNT_EN is defined.
interface logic_unit_if #(parameter int WIDTH = 32);
  import logic_unit_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in1;
  logic [WIDTH-1:0]  in2;
  logic [OP_W-1:0]   op;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out;
  logic              zero;
  logic              all_ones;
`ifdef LOGIC_UNIT_POPCOUNT_EN
  localparam int PC_W = $clog2(WIDTH+1);
  logic [PC_W-1:0]   pop_cnt;

  modport master (output in_valid, in1, in2, op, out_ready,
                  input  in_ready, out_valid, out, zero, all_ones, pop_cnt);
  modport slave  (input  in_valid, in1, in2, op, out_ready,
                  output in_ready, out_valid, out, zero, all_ones, pop_cnt);
`else
  modport master (output in_valid, in1, in2, op, out_ready,
                  input  in_ready, out_valid, out, zero, all_ones);
  modport slave  (input  in_valid, in1, in2, op, out_ready,
                  output in_ready, out_valid, out, zero, all_ones);
`endif

endinterface

// File: rtl/logic_unit_stage.sv
// Single valid/ready register slice. Accepts when empty or when its own
// content leaves on the same edge; payload is held while not advancing.
module logic_unit_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q,  data_d;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  // Next state: load on advance; data only changes when a real beat arrives.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready_o) begin
      valid_d = in_valid_i;
      if (in_valid_i) data_d = in_data_i;
    end
  end

  // Slice registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with Zero/AllOnes flags.
// Optional feature macro: LOGIC_UNIT_POPCOUNT_EN adds a registered
// population count of the result alongside the flags.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         rst_n,
  logic_unit_if.slave bus
);

  localparam int S1_W = OP_W + 2*WIDTH;
`ifdef LOGIC_UNIT_POPCOUNT_EN
  localparam int PC_W = $clog2(WIDTH+1);
  localparam int S2_W = PC_W + 2 + WIDTH;
`else
  localparam int S2_W = 2 + WIDTH;
`endif

  logic              s1_valid;
  logic              s2_ready;
  logic [S1_W-1:0]   s1_data;
  op_e               s1_op;
  logic [WIDTH-1:0]  s1_a, s1_b, res;
  logic              res_zero, res_ones;
  logic [S2_W-1:0]   s2_in, s2_out;

  // S1: operands and opcode as presented.
  logic_unit_stage #(.W(S1_W)) u_s1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (bus.in_ready),
    .in_data_i   ({bus.op, bus.in2, bus.in1}),
    .out_valid_o (s1_valid),
    .out_ready_i (s2_ready),
    .out_data_o  (s1_data)
  );

  assign s1_a  = s1_data[WIDTH-1:0];
  assign s1_b  = s1_data[2*WIDTH-1:WIDTH];
  assign s1_op = op_e'(s1_data[S1_W-1 -: OP_W]);

  assign res      = WIDTH'(lu_eval(s1_op, MAX_W'(s1_a), MAX_W'(s1_b)));
  assign res_zero = (res == '0);
  assign res_ones = (res == '1);

`ifdef LOGIC_UNIT_POPCOUNT_EN
  logic [PC_W-1:0] res_pc;

  // Count set bits of the result before it is registered in S2.
  always_comb begin
    res_pc = '0;
    for (int i = 0; i < WIDTH; i++) res_pc = res_pc + PC_W'(res[i]);
  end

  assign s2_in = {res_pc, res_ones, res_zero, res};
  assign {bus.pop_cnt, bus.all_ones, bus.zero, bus.out} = s2_out;
`else
  assign s2_in = {res_ones, res_zero, res};
  assign {bus.all_ones, bus.zero, bus.out} = s2_out;
`endif

  // S2: registered result and flags, held under backpressure.
  logic_unit_stage #(.W(S2_W)) u_s2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (s1_valid),
    .in_ready_o  (s2_ready),
    .in_data_i   (s2_in),
    .out_valid_o (bus.out_valid),
    .out_ready_i (bus.out_ready),
    .out_data_o  (s2_out)
  );

endmodule
